// File: rtl/debug_slave_pkg.sv
// Shared types and sizing helpers for the debug-slave system-clock side.
// Latency: n/a (types, constants and one sizing function only).
// Backpressure: n/a.
package debug_slave_pkg;

  localparam int DR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF) + 1;
  localparam int CNT_W_DEF = PTR_W_DEF;

  // Virtual IR opcodes decoded by the OCI/break/trace control logic.
  typedef enum logic [IR_W_DEF-1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_op_e;

  // One queued command at the default widths (consumer-side view).
  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [DR_W_DEF-1:0] dr;
  } cmd_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/debug_slave_strobe_sync.sv
// Synchronises one level-held TCK-domain strobe and emits a one-cycle rise pulse.
// Latency: pulse is high in the cycle after the SYNC_STAGES-th edge that sees the strobe.
// Backpressure: none; one pulse per rising edge of the strobe, never held off.
module debug_slave_strobe_sync
  import debug_slave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Shift the strobe through the synchroniser and remember the last synced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Captures completed JTAG DR scans into a queue and hands them to the CPU debug logic.
// Latency: cmd_valid rises SYNC_STAGES+2 edges after vs_udr is first sampled (empty queue).
// Backpressure: valid/ready; DEPTH entries buffered, scans arriving when full are dropped and flag overrun.
// Optional: DEBUG_SLAVE_UIR_FLUSH_EN makes every update-IR flush the queue.
module debug_slave_cmd_queue
  import debug_slave_pkg::*;
#(
  parameter int DR_W        = DR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DR_W-1:0]          sr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [DR_W-1:0]          jdo,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [IR_W-1:0]          ir_latched,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  // Same layout as cmd_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q, wptr_n, rptr_n;
  logic [PTR_W-1:0]   count, remain;
  logic [IDX_W-1:0]   head_idx;
  logic               udr_rise, uir_rise, flush;
  logic               full, pop, push_ok, drop, cmd_valid_n;

  debug_slave_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset_n(reset_n), .strobe(vs_udr), .rise(udr_rise)
  );

  debug_slave_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset_n(reset_n), .strobe(vs_uir), .rise(uir_rise)
  );

`ifdef DEBUG_SLAVE_UIR_FLUSH_EN
  assign flush = uir_rise;
`else
  assign flush = 1'b0;
`endif

  assign count     = wptr_q - rptr_q;
  assign cmd_count = count;
  assign full      = (count == PTR_W'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  // A flush frees the whole queue, so a coincident scan is always kept.
  assign push_ok   = udr_rise & (~full | pop | flush);
  assign drop      = udr_rise & full & ~pop & ~flush;

  // Next pointers, and the head presented after this edge; a scan pushed this
  // edge is not visible yet, which gives the one-cycle no-bypass step.
  always_comb begin
    wptr_n = wptr_q;
    rptr_n = rptr_q;
    if (flush)     rptr_n = wptr_q;
    else if (pop)  rptr_n = rptr_q + PTR_W'(1);
    if (push_ok)   wptr_n = wptr_q + PTR_W'(1);
    remain      = count - PTR_W'(pop);
    cmd_valid_n = ~flush & (remain != '0);
    head_idx    = rptr_n[IDX_W-1:0];
  end

  // Queue storage: the write uses the IR latched before any coincident update-IR.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[IDX_W-1:0]] <= '{ir: ir_latched, dr: sr};
  end

  // Pointers, registered head outputs, IR latch and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cmd_valid  <= 1'b0;
      jdo        <= '0;
      cmd_ir     <= '0;
      ir_latched <= '0;
      overrun    <= 1'b0;
    end else begin
      wptr_q    <= wptr_n;
      rptr_q    <= rptr_n;
      cmd_valid <= cmd_valid_n;
      if (cmd_valid_n) begin
        jdo    <= mem[head_idx].dr;
        cmd_ir <= mem[head_idx].ir;
      end
      if (uir_rise) ir_latched <= ir_in;
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Scoreboard bench for debug_slave_cmd_queue: scans push expected entries, the monitor pops and compares.
// Latency: checks the first-command latency of SYNC_STAGES+2 edges explicitly.
// Backpressure: exercises stall, full/drop, full push+pop, overrun clear priority, reset and update-IR.
module tb_debug_slave_cmd_queue;
  import debug_slave_pkg::*;

  localparam int DR_W  = 38;
  localparam int IR_W  = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n, vs_udr, vs_uir, cmd_ready, overrun_clr;
  logic [IR_W-1:0] ir_in;
  logic [DR_W-1:0] sr;
  logic            cmd_valid, overrun;
  logic [DR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir, ir_latched;
  logic [CW-1:0]   cmd_count;

  int              n_chk  = 0;
  int              n_pass = 0;
  int              n_pop  = 0;
  cmd_entry_t      exp_q[$];
  logic [IR_W-1:0] ir_model;

  always #5 clk = ~clk;

  debug_slave_cmd_queue #(.DR_W(DR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .jdo(jdo), .cmd_ir(cmd_ir),
    .ir_latched(ir_latched), .cmd_count(cmd_count), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor: every accepted command must match the oldest expected entry,
  // and a stalled head must not change.
  initial begin
    cmd_entry_t e;
    logic            prev_stall = 1'b0;
    logic [DR_W-1:0] prev_jdo   = '0;
    logic [IR_W-1:0] prev_ir    = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && cmd_valid) begin
        chk("hold_jdo", 64'(jdo), 64'(prev_jdo));
        chk("hold_ir", 64'(cmd_ir), 64'(prev_ir));
      end
      if (cmd_valid && cmd_ready) begin
        n_pop++;
        chk("sb_avail", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pop_jdo", 64'(jdo), 64'(e.dr));
          chk("pop_ir", 64'(cmd_ir), 64'(e.ir));
        end
      end
      prev_stall = cmd_valid & ~cmd_ready;
      prev_jdo   = jdo;
      prev_ir    = cmd_ir;
    end
  end

  task automatic uir_pulse(input logic [IR_W-1:0] ir);
    @(posedge clk); #1;
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (4) @(posedge clk);
    #1 vs_uir = 1'b0;
    ir_model = ir;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One DR scan; optional ready / overrun_clr pulse during the udr_rise cycle.
  task automatic scan(input logic [DR_W-1:0] d, input bit kept, input bit rdy_at_rise, input bit clr_at_rise);
    @(posedge clk); #1;
    sr     = d;
    vs_udr = 1'b1;
    if (kept) exp_q.push_back('{ir: ir_model, dr: d});
    repeat (2) @(posedge clk);
    #1;
    if (rdy_at_rise) cmd_ready = 1'b1;
    if (clr_at_rise) overrun_clr = 1'b1;
    @(posedge clk); #1;
    if (rdy_at_rise) cmd_ready = 1'b0;
    if (clr_at_rise) overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int cycles);
    @(posedge clk); #1 cmd_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 cmd_ready = 1'b0;
  endtask

  initial begin
    int pops_before;
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; overrun_clr = 1'b0;
    ir_in = '0; sr = '0; ir_model = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_cmd_ir", 64'(cmd_ir), 64'd0);
    chk("rst_ir_latched", 64'(ir_latched), 64'd0);
    chk("rst_count", 64'(cmd_count), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;

    // Single scan and first-command latency.
    uir_pulse(IR_BREAK);
    chk("ir_latched_2", 64'(ir_latched), 64'd2);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    sr     = 38'h2A_DEAD_BEEF;
    vs_udr = 1'b1;
    exp_q.push_back('{ir: ir_model, dr: 38'h2A_DEAD_BEEF});
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("lat_edge%0d", e), 64'(cmd_valid), 64'(e == 3));
    end
    @(posedge clk); @(negedge clk);
    chk("single_pulse", 64'(cmd_valid), 64'd0);
    #1 vs_udr = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Backpressure: fill, drop the fifth, then back-to-back drain.
    for (int i = 1; i <= 5; i++) scan(DR_W'(i), i <= 4, 1'b0, 1'b0);
    chk("full_count", 64'(cmd_count), 64'd4);
    chk("full_overrun", 64'(overrun), 64'd1);
    @(negedge clk);
    chk("stall_head", 64'(jdo), 64'd1);
    @(posedge clk); #1 cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", 64'(cmd_valid), 64'd1);
    end
    @(negedge clk);
    chk("drained_valid", 64'(cmd_valid), 64'd0);
    chk("drained_count", 64'(cmd_count), 64'd0);
    cmd_ready = 1'b0;

    // Full queue with push and pop in the same cycle.
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);
    for (int i = 11; i <= 14; i++) scan(DR_W'(i), 1'b1, 1'b0, 1'b0);
    scan(DR_W'(15), 1'b1, 1'b1, 1'b0);
    chk("pushpop_count", 64'(cmd_count), 64'd4);
    chk("pushpop_overrun", 64'(overrun), 64'd0);

    // Overrun set beats a coincident clear; clear alone works next.
    scan(DR_W'(16), 1'b0, 1'b0, 1'b1);
    chk("ovr_set_prio", 64'(overrun), 64'd1);
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    chk("ovr_clr_alone", 64'(overrun), 64'd0);
    drain(8);
    chk("drain2_count", 64'(cmd_count), 64'd0);

    // Reset mid-operation with vs_udr still high.
    for (int i = 21; i <= 23; i++) scan(DR_W'(i), 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(cmd_count), 64'd3);
    @(posedge clk); #1;
    sr     = DR_W'(24);
    vs_udr = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_count", 64'(cmd_count), 64'd0);
    exp_q.delete();
    ir_model = '0;
    #4 reset_n = 1'b1;
    exp_q.push_back('{ir: ir_model, dr: DR_W'(24)});
    pops_before = n_pop;
    cmd_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (6) @(posedge clk);
    #1 cmd_ready = 1'b0;
    chk("post_rst_cmds", 64'(n_pop - pops_before), 64'd1);

    // Update-IR with two queued commands.
    for (int i = 31; i <= 32; i++) scan(DR_W'(i), 1'b1, 1'b0, 1'b0);
    chk("pre_uir_count", 64'(cmd_count), 64'd2);
    @(posedge clk); #1;
    ir_in  = 2'd3;
    vs_uir = 1'b1;
    repeat (2) @(posedge clk);
`ifdef DEBUG_SLAVE_UIR_FLUSH_EN
    exp_q.delete();
`endif
    @(posedge clk); @(negedge clk);
`ifdef DEBUG_SLAVE_UIR_FLUSH_EN
    chk("flush_count", 64'(cmd_count), 64'd0);
    chk("flush_valid", 64'(cmd_valid), 64'd0);
`else
    chk("noflush_count", 64'(cmd_count), 64'd2);
`endif
    chk("uir_ir_latched", 64'(ir_latched), 64'd3);
    #1 vs_uir = 1'b0;
    ir_model = 2'd3;
    repeat (3) @(posedge clk);
    drain(6);
    chk("final_count", 64'(cmd_count), 64'd0);
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/debug_slave_cmd_queue.md
Name: debug_slave_cmd_queue

Overview:
- Next-generation system-clock side of the CPU JTAG debug slave. It replaces the fixed 38-bit, 2-bit-IR, single-shot decoder with a parametrised DR/IR width and a command queue.
- Takes the level-held update-DR and update-IR strobes and the shift register from the TCK domain. It synchronises them, captures each completed DR scan, and presents it to the CPU debug logic over a valid/ready handshake.
- Scans are no longer lost when the core is busy.
- Sits between the virtual-JTAG TCK block and the OCI/break/trace control logic.

Parameters:
- DR_W, 38, data-register (shift register) width in bits.
- IR_W, 2, virtual instruction-register width.
- DEPTH, 4, command queue entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flip-flop stages on each strobe synchroniser; minimum 2.

Ports:
- clk  in  1  system clock; sole clock of the block.
- reset_n  in  1  asynchronous active-low reset.
- vs_udr  in  1  update-DR strobe from TCK domain, asynchronous, level-held.
- vs_uir  in  1  update-IR strobe from TCK domain, asynchronous, level-held.
- ir_in  in  IR_W  current virtual IR value; quasi-static.
- sr  in  DR_W  TCK-domain shift register; stable while vs_udr is high.
- cmd_valid  out  1  queue head holds a command.
- cmd_ready  in  1  consumer accepts head this cycle.
- jdo  out  DR_W  DR payload of queue head.
- cmd_ir  out  IR_W  IR value captured with the head command.
- ir_latched  out  IR_W  IR value captured at the last update-IR.
- cmd_count  out  $clog2(DEPTH)+1  number of queued commands.
- overrun  out  1  sticky: a scan was dropped because the queue was full.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, active-low): all synchroniser stages 0; edge registers 0; queue empty.
- Output reset values: cmd_valid=0, jdo=0, cmd_ir=0, ir_latched=0, cmd_count=0, overrun=0.
- Synchronisation: vs_udr and vs_uir each pass through SYNC_STAGES flops, followed by one edge register. udr_rise = sync & ~edge_reg; uir_rise likewise. Each is a single-cycle pulse per rising edge.
- Capture: on udr_rise, {ir_latched, sr} is pushed as one entry. sr and ir_in are sampled directly; the TCK side guarantees they are stable from vs_udr rise until after the pulse.
- On uir_rise, ir_latched <= ir_in.
- If udr_rise and uir_rise coincide, the push uses the old ir_latched value and ir_latched then updates.
- Latency: first clk edge sampling vs_udr=1 is edge 0. cmd_valid rises after edge SYNC_STAGES+1 when the queue was empty, i.e. 4 edges for default SYNC_STAGES=2.
- jdo and cmd_ir are registered from the head entry and valid whenever cmd_valid=1. Otherwise they hold their last value.
- Handshake: pop happens when cmd_valid & cmd_ready. cmd_valid is not withdrawn without a pop. Payload holds stable while cmd_valid & ~cmd_ready.
- Back-to-back pops are supported: one command per cycle at full throughput.
- Queue control: circular buffer, read/write pointers with a wrap bit, DEPTH+1 count states.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: entry is written; cmd_valid rises next cycle (no bypass).
  - Push when full without pop: entry dropped, contents unchanged, overrun <= 1.
  - Pointers wrap modulo DEPTH.
- overrun: set has priority over overrun_clr in the same cycle.
- cmd_count equals the number of valid entries; it updates in the same cycle as the push/pop register update.
- Reset mid-operation: queue emptied immediately and pending pulses lost. A vs_udr still high at deassertion produces one udr_rise after synchronisation; this is intended, because the edge register was 0.

Optional Feature:
- Macro: DEBUG_SLAVE_UIR_FLUSH_EN.
- Defined: each uir_rise empties the queue (both pointers to write pointer) in the same cycle as the ir_latched update. cmd_valid drops on the next cycle.
  - A pop coinciding with the flush is accepted by the consumer but has no further effect.
  - A push coinciding with the flush is kept as the only entry.
- Not defined: uir_rise only updates ir_latched; queued commands are unaffected.

Decomposition:
- Shared package debug_slave_pkg: cmd_entry_t struct {ir, dr}; localparams for pointer width and count width; IR opcode constants (IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3).
- One natural sub-module: debug_slave_strobe_sync (SYNC_STAGES parameter, async reset, rise-pulse output), instantiated twice.

Test Plan:
- Single scan: cmd_ready=1, sr=38'h2A_DEAD_BEEF, ir_in=2'b10 with vs_uir then vs_udr pulsed → ir_latched=2. One cmd_valid pulse 4 edges after udr sampled, with jdo=38'h2A_DEAD_BEEF and cmd_ir=2.
- Backpressure/full: cmd_ready=0, five scans with sr=1..5 → cmd_count=4, overrun=1, queue holds 1..4. Then cmd_ready=1 → four consecutive pops of 1,2,3,4, then cmd_valid=0.
- Full with simultaneous push and pop: queue full, cmd_ready=1 on the udr_rise cycle → count stays 4, overrun stays 0, new entry appears last.
- Overrun priority: overrun_clr=1 in the same cycle as a dropped push → overrun stays 1. Next cycle overrun_clr=1 alone → overrun=0.
- Reset mid-operation: 3 queued entries, reset_n pulsed low for half a cycle → cmd_valid=0 and cmd_count=0 immediately. vs_udr held high → exactly one new command after release.
- UIR flush (macro defined): 2 queued entries, then a uir with ir_in=3 → cmd_count=0 next cycle, ir_latched=3. Macro undefined: count stays 2.
